// File: rtl/data_cache_line_fill.sv
// Purpose  : cache line fill engine; picks a victim way, invalidates it, streams a line
//            from memory into the data array, then writes tag + valid.
// Latency  : request-to-done BLOCK_WORDS+2 cycles minimum; all outputs registered.
// Backpres.: none towards memory (every mem_valid_i beat in FILL is consumed); fill_req_i
//            is ignored while busy_o is high.
// Ports    : clk_i/rst_i clock and async active-high reset; fill_req_i/fill_tag_i/
//            fill_index_i/set_valid_i miss request; busy_o/fill_done_o/fill_way_o status;
//            mem_req_o/mem_address_o/mem_valid_i/mem_data_i memory side; cache_* /data_* /
//            tag_o/valid_o array write side.
module data_cache_line_fill #(
    parameter int WAYS_NUMBER = 4,
    parameter int WAY_ADDR    = $clog2(WAYS_NUMBER),
    parameter int PORT_WIDTH  = 32,
    parameter int TAG_SIZE    = 20,
    parameter int INDEX_SIZE  = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int OFFSET_SIZE = $clog2(BLOCK_WORDS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           fill_req_i,
    input  logic [TAG_SIZE-1:0]            fill_tag_i,
    input  logic [INDEX_SIZE-1:0]          fill_index_i,
    input  logic [WAYS_NUMBER-1:0]         set_valid_i,
    output logic                           busy_o,
    output logic                           fill_done_o,
    output logic [WAY_ADDR-1:0]            fill_way_o,
    output logic                           mem_req_o,
    output logic [TAG_SIZE+INDEX_SIZE-1:0] mem_address_o,
    input  logic                           mem_valid_i,
    input  logic [PORT_WIDTH-1:0]          mem_data_i,
    output logic [WAYS_NUMBER-1:0]         cache_way_enable_o,
    output logic [INDEX_SIZE-1:0]          cache_index_o,
    output logic                           data_write_o,
    output logic [OFFSET_SIZE-1:0]         data_offset_o,
    output logic [PORT_WIDTH-1:0]          data_o,
    output logic                           tag_write_o,
    output logic [TAG_SIZE-1:0]            tag_o,
    output logic                           valid_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQUEST = 2'd1;
    localparam logic [1:0] S_FILL    = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    localparam logic [OFFSET_SIZE-1:0] LAST_BEAT = OFFSET_SIZE'(BLOCK_WORDS - 1);

    logic [1:0]                      r_state;
    logic [WAY_ADDR-1:0]             r_rr_cnt;
    logic [OFFSET_SIZE-1:0]          r_beat_cnt;
    logic                            r_busy;
    logic                            r_fill_done;
    logic [WAY_ADDR-1:0]             r_fill_way;
    logic                            r_mem_req;
    logic [TAG_SIZE+INDEX_SIZE-1:0]  r_mem_address;
    logic [WAYS_NUMBER-1:0]          r_way_en;
    logic [INDEX_SIZE-1:0]           r_index;
    logic                            r_data_write;
    logic [OFFSET_SIZE-1:0]          r_data_offset;
    logic [PORT_WIDTH-1:0]           r_data;
    logic                            r_tag_write;
    logic [TAG_SIZE-1:0]             r_tag;
    logic                            r_valid;

    logic                            w_has_invalid;
    logic [WAY_ADDR-1:0]             w_first_invalid;
    logic [WAY_ADDR-1:0]             w_victim;
    logic [WAYS_NUMBER-1:0]          w_victim_oh;
    logic [WAYS_NUMBER-1:0]          w_fill_way_oh;

    // Scan from the top so the lowest-index invalid way is the last one to win.
    always_comb begin
        w_has_invalid   = 1'b0;
        w_first_invalid = '0;
        for (int i = WAYS_NUMBER - 1; i >= 0; i--) begin
            if (!set_valid_i[i]) begin
                w_has_invalid   = 1'b1;
                w_first_invalid = WAY_ADDR'(i);
            end
        end
    end

    assign w_victim      = w_has_invalid ? w_first_invalid : r_rr_cnt;
    assign w_victim_oh   = WAYS_NUMBER'(1) << w_victim;
    assign w_fill_way_oh = WAYS_NUMBER'(1) << r_fill_way;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_rr_cnt      <= '0;
            r_beat_cnt    <= '0;
            r_busy        <= 1'b0;
            r_fill_done   <= 1'b0;
            r_fill_way    <= '0;
            r_mem_req     <= 1'b0;
            r_mem_address <= '0;
            r_way_en      <= '0;
            r_index       <= '0;
            r_data_write  <= 1'b0;
            r_data_offset <= '0;
            r_data        <= '0;
            r_tag_write   <= 1'b0;
            r_tag         <= '0;
            r_valid       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_mem_req    <= 1'b0;
            r_tag_write  <= 1'b0;
            r_data_write <= 1'b0;
            r_fill_done  <= 1'b0;
            r_valid      <= 1'b0;
            r_way_en     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (fill_req_i) begin
                        r_state       <= S_REQUEST;
                        r_busy        <= 1'b1;
                        r_tag         <= fill_tag_i;
                        r_index       <= fill_index_i;
                        r_mem_address <= {fill_tag_i, fill_index_i};
                        r_fill_way    <= w_victim;
                        // Invalidate the victim in REQUEST so a torn fill never hits.
                        r_mem_req     <= 1'b1;
                        r_tag_write   <= 1'b1;
                        r_way_en      <= w_victim_oh;
                        if (!w_has_invalid) begin
                            r_rr_cnt <= r_rr_cnt + WAY_ADDR'(1);
                        end
                    end
                end
                S_REQUEST: begin
                    r_state <= S_FILL;
                end
                S_FILL: begin
                    if (mem_valid_i) begin
                        r_data_write  <= 1'b1;
                        r_data_offset <= r_beat_cnt;
                        r_data        <= mem_data_i;
                        r_way_en      <= w_fill_way_oh;
                        r_beat_cnt    <= r_beat_cnt + OFFSET_SIZE'(1);
                        // Last word lands in the same cycle as the tag/valid commit.
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state     <= S_COMMIT;
                            r_tag_write <= 1'b1;
                            r_valid     <= 1'b1;
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o             = r_busy;
    assign fill_done_o        = r_fill_done;
    assign fill_way_o         = r_fill_way;
    assign mem_req_o          = r_mem_req;
    assign mem_address_o      = r_mem_address;
    assign cache_way_enable_o = r_way_en;
    assign cache_index_o      = r_index;
    assign data_write_o       = r_data_write;
    assign data_offset_o      = r_data_offset;
    assign data_o             = r_data;
    assign tag_write_o        = r_tag_write;
    assign tag_o              = r_tag;
    assign valid_o            = r_valid;

endmodule

// File: tb/tb_data_cache_line_fill.sv
// Purpose  : directed self-checking bench for data_cache_line_fill.
// Latency  : inputs change 1ns after a rising edge, outputs are checked at the same point.
// Backpres.: not applicable; every wait is a fixed cycle count.
module tb_data_cache_line_fill;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fill_req_i = 1'b0;
    logic [19:0] fill_tag_i = '0;
    logic [7:0]  fill_index_i = '0;
    logic [3:0]  set_valid_i = '0;
    logic        busy_o;
    logic        fill_done_o;
    logic [1:0]  fill_way_o;
    logic        mem_req_o;
    logic [27:0] mem_address_o;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic [3:0]  cache_way_enable_o;
    logic [7:0]  cache_index_o;
    logic        data_write_o;
    logic [1:0]  data_offset_o;
    logic [31:0] data_o;
    logic        tag_write_o;
    logic [19:0] tag_o;
    logic        valid_o;

    int total = 0;
    int bad   = 0;

    data_cache_line_fill dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .fill_req_i         (fill_req_i),
        .fill_tag_i         (fill_tag_i),
        .fill_index_i       (fill_index_i),
        .set_valid_i        (set_valid_i),
        .busy_o             (busy_o),
        .fill_done_o        (fill_done_o),
        .fill_way_o         (fill_way_o),
        .mem_req_o          (mem_req_o),
        .mem_address_o      (mem_address_o),
        .mem_valid_i        (mem_valid_i),
        .mem_data_i         (mem_data_i),
        .cache_way_enable_o (cache_way_enable_o),
        .cache_index_o      (cache_index_o),
        .data_write_o       (data_write_o),
        .data_offset_o      (data_offset_o),
        .data_o             (data_o),
        .tag_write_o        (tag_write_o),
        .tag_o              (tag_o),
        .valid_o            (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},  64'(busy_o), 64'd0);
        check({tag, ".done"},  64'(fill_done_o), 64'd0);
        check({tag, ".way"},   64'(fill_way_o), 64'd0);
        check({tag, ".mreq"},  64'(mem_req_o), 64'd0);
        check({tag, ".maddr"}, 64'(mem_address_o), 64'd0);
        check({tag, ".wen"},   64'(cache_way_enable_o), 64'd0);
        check({tag, ".idx"},   64'(cache_index_o), 64'd0);
        check({tag, ".dwr"},   64'(data_write_o), 64'd0);
        check({tag, ".doff"},  64'(data_offset_o), 64'd0);
        check({tag, ".dat"},   64'(data_o), 64'd0);
        check({tag, ".twr"},   64'(tag_write_o), 64'd0);
        check({tag, ".tag"},   64'(tag_o), 64'd0);
        check({tag, ".vld"},   64'(valid_o), 64'd0);
    endtask

    // Issue one request (cycle 0) and check the REQUEST cycle (cycle 1). A stray
    // mem_valid_i pulse is driven during REQUEST; it must not count as a beat.
    task automatic start_fill(input string tag, input logic [3:0] sv, input logic [19:0] tg,
                              input logic [7:0] ix, input logic [1:0] exp_way);
        fill_req_i   = 1'b1;
        set_valid_i  = sv;
        fill_tag_i   = tg;
        fill_index_i = ix;
        tick();
        check({tag, ".req_way"},  64'(fill_way_o), 64'(exp_way));
        check({tag, ".req_wen"},  64'(cache_way_enable_o), 64'(4'b0001 << exp_way));
        check({tag, ".req_mreq"}, 64'(mem_req_o), 64'd1);
        check({tag, ".req_addr"}, 64'(mem_address_o), 64'({tg, ix}));
        check({tag, ".req_twr"},  64'(tag_write_o), 64'd1);
        check({tag, ".req_vld"},  64'(valid_o), 64'd0);
        check({tag, ".req_tag"},  64'(tag_o), 64'(tg));
        check({tag, ".req_idx"},  64'(cache_index_o), 64'(ix));
        check({tag, ".req_busy"}, 64'(busy_o), 64'd1);
        mem_valid_i = 1'b1;
        mem_data_i  = 32'hDEAD_BEEF;
        tick();
        mem_valid_i = 1'b0;
        check({tag, ".c2_dwr"},  64'(data_write_o), 64'd0);
        check({tag, ".c2_mreq"}, 64'(mem_req_o), 64'd0);
        check({tag, ".c2_twr"},  64'(tag_write_o), 64'd0);
    endtask

    // Full fill: `gap` idle cycles before each beat; fill_req_i stays high if hold=1.
    task automatic run_fill(input string tag, input logic [3:0] sv, input logic [19:0] tg,
                            input logic [7:0] ix, input logic [1:0] exp_way,
                            input int gap, input bit hold, input logic [31:0] base);
        start_fill(tag, sv, tg, ix, exp_way);
        if (!hold) fill_req_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                check({tag, ".gap_dwr"}, 64'(data_write_o), 64'd0);
                check({tag, ".gap_wen"}, 64'(cache_way_enable_o), 64'd0);
            end
            mem_valid_i = 1'b1;
            mem_data_i  = base + 32'(b);
            tick();
            mem_valid_i = 1'b0;
            check({tag, ".dwr"},  64'(data_write_o), 64'd1);
            check({tag, ".doff"}, 64'(data_offset_o), 64'(b));
            check({tag, ".dat"},  64'(data_o), 64'(base + 32'(b)));
            check({tag, ".wen"},  64'(cache_way_enable_o), 64'(4'b0001 << exp_way));
            check({tag, ".done"}, 64'(fill_done_o), (b == 3) ? 64'd1 : 64'd0);
            check({tag, ".twr"},  64'(tag_write_o), (b == 3) ? 64'd1 : 64'd0);
            check({tag, ".vld"},  64'(valid_o), (b == 3) ? 64'd1 : 64'd0);
            check({tag, ".busy"}, 64'(busy_o), 64'd1);
            check({tag, ".mreq"}, 64'(mem_req_o), 64'd0);
        end
        tick();
        check({tag, ".end_busy"}, 64'(busy_o), 64'd0);
        check({tag, ".end_done"}, 64'(fill_done_o), 64'd0);
        check({tag, ".end_twr"},  64'(tag_write_o), 64'd0);
        check({tag, ".end_dwr"},  64'(data_write_o), 64'd0);
        check({tag, ".end_wen"},  64'(cache_way_enable_o), 64'd0);
        check({tag, ".end_mreq"}, 64'(mem_req_o), 64'd0);
        check({tag, ".hold_way"}, 64'(fill_way_o), 64'(exp_way));
        check({tag, ".hold_idx"}, 64'(cache_index_o), 64'(ix));
    endtask

    initial begin
        #2;
        check_all_zero("rst");
        tick();
        rst_i = 1'b0;
        tick();
        check_all_zero("post_rst");

        // Lowest invalid way of 1011 is 2; round-robin stays at 0.
        run_fill("t1", 4'b1011, 20'h12345, 8'h3A, 2'd2, 0, 1'b0, 32'hA0);

        // Full sets walk the round-robin counter 0,1,2,3,0.
        run_fill("rr0", 4'b1111, 20'h00001, 8'h01, 2'd0, 0, 1'b0, 32'h100);
        run_fill("rr1", 4'b1111, 20'h00002, 8'h02, 2'd1, 0, 1'b0, 32'h200);
        run_fill("rr2", 4'b1111, 20'h00003, 8'h03, 2'd2, 0, 1'b0, 32'h300);
        run_fill("rr3", 4'b1111, 20'h00004, 8'h04, 2'd3, 0, 1'b0, 32'h400);
        run_fill("rr4", 4'b1111, 20'h00005, 8'h05, 2'd0, 0, 1'b0, 32'h500);
        // Invalid way 0 chosen; counter (now 1) must not move.
        run_fill("inv", 4'b1110, 20'h00006, 8'h06, 2'd0, 0, 1'b0, 32'h600);
        run_fill("rr5", 4'b1111, 20'h00007, 8'h07, 2'd1, 0, 1'b0, 32'h700);

        // Two idle cycles before every beat; counter 2 -> victim 2.
        run_fill("gap", 4'b1111, 20'hABCDE, 8'hF0, 2'd2, 2, 1'b0, 32'hC0DE_0000);

        // fill_req_i held high: second fill begins in the first IDLE cycle.
        run_fill("hold1", 4'b1111, 20'h11111, 8'h11, 2'd3, 0, 1'b1, 32'h1100);
        check("hold.req_still_high", 64'(fill_req_i), 64'd1);
        run_fill("hold2", 4'b1111, 20'h22222, 8'h22, 2'd0, 0, 1'b0, 32'h2200);

        // Reset after beat 2 (counter is 1 -> victim 1, counter becomes 2).
        start_fill("prt", 4'b1111, 20'h33333, 8'h33, 2'd1);
        fill_req_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_valid_i = 1'b1;
            mem_data_i  = 32'h3300 + 32'(b);
            tick();
        end
        mem_valid_i = 1'b0;
        check("prt.dwr_b2",  64'(data_write_o), 64'd1);
        check("prt.doff_b2", 64'(data_offset_o), 64'd2);
        #2;
        rst_i = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        check("mid_rst.no_commit", 64'(fill_done_o), 64'd0);
        rst_i = 1'b0;
        tick();
        check_all_zero("mid_rst_rel");
        // Round-robin back to 0, beat counter back to offset 0.
        run_fill("after_rst", 4'b1111, 20'h44444, 8'h44, 2'd0, 0, 1'b0, 32'h4400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
